// File: rtl/synapse_scheduler.sv
// Time-multiplexed synapse current scheduler: one tick sweeps every synapse through a shared decay/weight datapath.
// Optional macro SYN_SUM_EN adds sum_current, a saturating sum of the sweep's outputs.
module synapse_scheduler #(
   parameter int          N_SYN = 8,
   parameter logic [15:0] DECAY = 16'h7EB8,
   parameter int          AW    = $clog2(N_SYN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic [N_SYN-1:0] spike_in,
   input  logic             w_we,
   input  logic [AW-1:0]    w_addr,
   input  logic [15:0]      w_data,
   output logic             busy,
   output logic             out_valid,
   output logic [AW-1:0]    out_idx,
   output logic [15:0]      out_current,
   output logic             done,
   output logic             tick_drop
`ifdef SYN_SUM_EN
   ,
   output logic [15:0]      sum_current
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

   localparam logic signed [15:0] DECAY_S = DECAY;
   localparam logic [AW-1:0]      LAST    = AW'(N_SYN - 1);

   // Sign-magnitude Q1.15 multiply, product truncated toward zero in magnitude.
   function automatic logic signed [15:0] q15_mul(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
      logic [15:0]        ma;
      logic [15:0]        mb;
      logic [29:0]        prod;
      logic signed [15:0] r;
      ma   = a[15] ? (~a + 16'd1) : a;
      mb   = b[15] ? (~b + 16'd1) : b;
      prod = 30'(ma[14:0]) * 30'(mb[14:0]);
      r    = {1'b0, prod[29:15]};
      if (a[15] ^ b[15]) r = -r;
      return r;
   endfunction

   function automatic logic [15:0] sat_pos(input logic [15:0] v);
      return v[15] ? 16'h7FFF : v;
   endfunction

   state_t             state_q;
   logic [AW-1:0]      idx_q;
   logic [N_SYN-1:0]   spk_q;
   logic               busy_q;
   logic               out_valid_q;
   logic [AW-1:0]      out_idx_q;
   logic [15:0]        out_current_q;
   logic               done_q;
   logic               tick_drop_q;
   logic signed [15:0] cur_q [N_SYN];
   logic signed [15:0] w_q   [N_SYN];

   logic signed [15:0] decayed;
   logic signed [15:0] w_add;
   logic [15:0]        cur_d;

   always_comb begin
      decayed = q15_mul(cur_q[idx_q], DECAY_S);
      w_add   = spk_q[idx_q] ? w_q[idx_q] : 16'sd0;
      cur_d   = sat_pos(decayed + w_add);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         spk_q         <= '0;
         busy_q        <= 1'b0;
         out_valid_q   <= 1'b0;
         out_idx_q     <= '0;
         out_current_q <= '0;
         done_q        <= 1'b0;
         tick_drop_q   <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         tick_drop_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (tick) begin
                  spk_q   <= spike_in;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_SWEEP;
               end
            end
            S_SWEEP: begin
               out_valid_q   <= 1'b1;
               out_idx_q     <= idx_q;
               out_current_q <= cur_d;
               tick_drop_q   <= tick;
               if (idx_q == LAST) state_q <= S_DONE;
               else               idx_q   <= idx_q + AW'(1);
            end
            S_DONE: begin
               done_q      <= 1'b1;
               busy_q      <= 1'b0;
               tick_drop_q <= tick;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Read happens before the write lands, so a same-cycle weight write is not seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_SYN; i++) w_q[i] <= '0;
      end else if (w_we && (int'(w_addr) < N_SYN)) begin
         w_q[w_addr] <= {1'b0, w_data[14:0]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_SYN; i++) cur_q[i] <= '0;
      end else if (state_q == S_SWEEP) begin
         cur_q[idx_q] <= cur_d;
      end
   end

`ifdef SYN_SUM_EN
   logic [15:0] sum_q;

   // Outputs are never negative, so an overflowing add always shows up in bit 15.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            sum_q <= '0;
      else if (state_q == S_IDLE && tick)    sum_q <= '0;
      else if (state_q == S_SWEEP)           sum_q <= sat_pos(sum_q + cur_d);
   end

   assign sum_current = sum_q;
`endif

   assign busy        = busy_q;
   assign out_valid   = out_valid_q;
   assign out_idx     = out_idx_q;
   assign out_current = out_current_q;
   assign done        = done_q;
   assign tick_drop   = tick_drop_q;

endmodule
